// File: rtl/mac_seq_ctrl.sv
// Dot-product sequencer: frames operand pairs into VEC_LEN-beat MAC runs and requantizes the result.
// Optional round-half-up requantization is enabled by defining MAC_SEQ_ROUND_EN (default: truncate).
module mac_seq_ctrl #(
   parameter int DATA_WIDTH   = 16,
   parameter int WEIGHT_WIDTH = 8,
   parameter int ACCUM_WIDTH  = 24,
   parameter int OUT_WIDTH    = 16,
   parameter int VEC_LEN      = 8,
   parameter int FRAC_SHIFT   = 6
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [DATA_WIDTH-1:0]   in_data,
   input  logic [WEIGHT_WIDTH-1:0] in_weight,
   output logic                    mac_enable,
   output logic                    mac_clear_accum,
   output logic [DATA_WIDTH-1:0]   mac_data,
   output logic [WEIGHT_WIDTH-1:0] mac_weight,
   input  logic [ACCUM_WIDTH-1:0]  mac_accum,
   input  logic                    mac_valid,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [OUT_WIDTH-1:0]    out_data,
   output logic                    out_sat,
   output logic                    busy
);

   localparam int CW = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
   localparam logic [CW-1:0] LAST = CW'(VEC_LEN - 1);
   localparam int SW = ACCUM_WIDTH + 1;
   localparam logic signed [SW-1:0] OUT_MAX = {{(SW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
   localparam logic signed [SW-1:0] OUT_MIN = {{(SW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {FILL, DRAIN, HOLD} state_t;

   state_t                  state_q, state_d;
   logic [CW-1:0]           issue_cnt_q, issue_cnt_d;
   logic [CW-1:0]           ret_cnt_q, ret_cnt_d;
   logic                    mac_enable_q, mac_enable_d;
   logic                    mac_clear_q, mac_clear_d;
   logic [DATA_WIDTH-1:0]   mac_data_q, mac_data_d;
   logic [WEIGHT_WIDTH-1:0] mac_weight_q, mac_weight_d;
   logic [OUT_WIDTH-1:0]    out_data_q, out_data_d;
   logic                    out_sat_q, out_sat_d;

   logic                    accept;
   logic signed [SW-1:0]    acc_ext, acc_rnd, acc_shift;
   logic [OUT_WIDTH-1:0]    rq_data;
   logic                    rq_sat;

   // One extra guard bit keeps the rounding add from overflowing the accumulator range.
   always_comb begin
      acc_ext = {mac_accum[ACCUM_WIDTH-1], mac_accum};
`ifdef MAC_SEQ_ROUND_EN
      acc_rnd = acc_ext + SW'(1 << (FRAC_SHIFT - 1));
`else
      acc_rnd = acc_ext;
`endif
      acc_shift = acc_rnd >>> FRAC_SHIFT;
      rq_data   = acc_shift[OUT_WIDTH-1:0];
      rq_sat    = 1'b0;
      if (acc_shift > OUT_MAX) begin
         rq_data = OUT_MAX[OUT_WIDTH-1:0];
         rq_sat  = 1'b1;
      end else if (acc_shift < OUT_MIN) begin
         rq_data = OUT_MIN[OUT_WIDTH-1:0];
         rq_sat  = 1'b1;
      end
   end

   always_comb begin
      state_d      = state_q;
      issue_cnt_d  = issue_cnt_q;
      ret_cnt_d    = ret_cnt_q;
      mac_enable_d = 1'b0;
      mac_clear_d  = 1'b0;
      mac_data_d   = mac_data_q;
      mac_weight_d = mac_weight_q;
      out_data_d   = out_data_q;
      out_sat_d    = out_sat_q;
      accept       = in_valid && (state_q == FILL);

      if (accept) begin
         mac_enable_d = 1'b1;
         mac_clear_d  = (issue_cnt_q == '0);
         mac_data_d   = in_data;
         mac_weight_d = in_weight;
         if (issue_cnt_q == LAST) begin
            issue_cnt_d = '0;
            state_d     = DRAIN;
         end else begin
            issue_cnt_d = issue_cnt_q + CW'(1);
         end
      end

      // Returns are only meaningful while a vector is in flight; in HOLD they are dropped.
      if (mac_valid && (state_q != HOLD)) begin
         if (ret_cnt_q == LAST) begin
            ret_cnt_d  = '0;
            out_data_d = rq_data;
            out_sat_d  = rq_sat;
            state_d    = HOLD;
         end else begin
            ret_cnt_d = ret_cnt_q + CW'(1);
         end
      end

      if ((state_q == HOLD) && out_ready) begin
         state_d = FILL;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= FILL;
         issue_cnt_q  <= '0;
         ret_cnt_q    <= '0;
         mac_enable_q <= 1'b0;
         mac_clear_q  <= 1'b0;
         mac_data_q   <= '0;
         mac_weight_q <= '0;
         out_data_q   <= '0;
         out_sat_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         issue_cnt_q  <= issue_cnt_d;
         ret_cnt_q    <= ret_cnt_d;
         mac_enable_q <= mac_enable_d;
         mac_clear_q  <= mac_clear_d;
         mac_data_q   <= mac_data_d;
         mac_weight_q <= mac_weight_d;
         out_data_q   <= out_data_d;
         out_sat_q    <= out_sat_d;
      end
   end

   assign in_ready        = (state_q == FILL) && !rst;
   assign mac_enable      = mac_enable_q;
   assign mac_clear_accum = mac_clear_q;
   assign mac_data        = mac_data_q;
   assign mac_weight      = mac_weight_q;
   assign out_valid       = (state_q == HOLD);
   assign out_data        = out_data_q;
   assign out_sat         = out_sat_q;
   assign busy            = (state_q != FILL) || (issue_cnt_q != '0);

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Self-checking bench for mac_seq_ctrl: a behavioural mac_unit, a beat-level reference model
// checked every cycle, directed literal vectors and randomized vectors.
module tb_mac_seq_ctrl;

   localparam int DW = 16;
   localparam int WW = 8;
   localparam int AW = 24;
   localparam int OW = 16;
   localparam int VL = 8;
   localparam int FS = 6;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [DW-1:0] in_data = '0;
   logic [WW-1:0] in_weight = '0;
   logic          mac_enable;
   logic          mac_clear_accum;
   logic [DW-1:0] mac_data;
   logic [WW-1:0] mac_weight;
   logic [AW-1:0] mac_accum;
   logic          mac_valid;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [OW-1:0] out_data;
   logic          out_sat;
   logic          busy;

   int testsRun = 0;
   int testsFailed = 0;

   mac_seq_ctrl #(
      .DATA_WIDTH(DW), .WEIGHT_WIDTH(WW), .ACCUM_WIDTH(AW),
      .OUT_WIDTH(OW), .VEC_LEN(VL), .FRAC_SHIFT(FS)
   ) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_weight(in_weight),
      .mac_enable(mac_enable), .mac_clear_accum(mac_clear_accum),
      .mac_data(mac_data), .mac_weight(mac_weight),
      .mac_accum(mac_accum), .mac_valid(mac_valid),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat),
      .busy(busy)
   );

   // Free-running 10-unit clock
   always #5 clk = ~clk;

   task automatic compare(input string name, input longint act, input longint exp);
      testsRun++;
      if (act != exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [AW-1:0] macProd(input logic [DW-1:0] d, input logic [WW-1:0] w);
      int p;
      p = int'($signed(d)) * int'($signed(w));
      return p[AW-1:0];
   endfunction

   // Reference requantization: S7.16 value to S5.10 by plain arithmetic and clamping
   function automatic void requant(input longint acc, output logic [OW-1:0] d, output bit s);
      longint v;
      v = acc;
`ifdef MAC_SEQ_ROUND_EN
      v = v + longint'(1 << (FS - 1));
`endif
      v = v >>> FS;
      if (v > 32767) begin
         d = 16'h7FFF;
         s = 1'b1;
      end else if (v < -32768) begin
         d = 16'h8000;
         s = 1'b1;
      end else begin
         d = 16'(v);
         s = 1'b0;
      end
   endfunction

   // Behavioural mac_unit: one-cycle multiply-accumulate, valid follows enable by one cycle
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mac_valid <= 1'b0;
         mac_accum <= '0;
      end else begin
         mac_valid <= mac_enable;
         if (mac_enable)
            mac_accum <= (mac_clear_accum ? '0 : mac_accum) + macProd(mac_data, mac_weight);
      end
   end

   // Reference model at beat/vector level: counts beats in the current vector, keeps the
   // exact dot product, and schedules the result two edges after the last beat
   int            cyc = 0;
   int            beatsInVec = 0;
   int            readyEdge = 0;
   longint        sum = 0;
   bit            expEn = 0, expClr = 0, expOutValid = 0, pending = 0, expSat = 0;
   bit            preValid, preReady;
   logic [DW-1:0] expData = '0;
   logic [WW-1:0] expWt = '0;
   logic [OW-1:0] expOut = '0;
   logic [AW-1:0] sumTrunc;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         beatsInVec  = 0;
         pending     = 0;
         expOutValid = 0;
         expEn       = 0;
         expClr      = 0;
         sum         = 0;
      end else begin
         cyc++;
         preValid = expOutValid;
         preReady = (beatsInVec < VL);
         expEn    = 0;
         expClr   = 0;
         if (preValid && out_ready) begin
            expOutValid = 0;
            pending     = 0;
            beatsInVec  = 0;
         end else if (pending && cyc == readyEdge) begin
            expOutValid = 1;
         end
         if (in_valid && preReady) begin
            expEn   = 1;
            expClr  = (beatsInVec == 0);
            expData = in_data;
            expWt   = in_weight;
            if (beatsInVec == 0) sum = 0;
            sum = sum + longint'(int'($signed(in_data)) * int'($signed(in_weight)));
            beatsInVec++;
            if (beatsInVec == VL) begin
               pending   = 1;
               readyEdge = cyc + 2;
               sumTrunc  = sum[AW-1:0];
               requant(longint'($signed(sumTrunc)), expOut, expSat);
            end
         end
      end
   end

   // Single compare process: every cycle, away from the active edge
   always @(negedge clk) begin
      if (rst) begin
         compare("resetInReady", in_ready, 0);
         compare("resetOutputs",
                 {mac_enable, mac_clear_accum, mac_data, mac_weight, out_valid, out_data, out_sat, busy}, 0);
      end else begin
         compare("inReady", in_ready, (beatsInVec < VL));
         compare("macEnable", mac_enable, expEn);
         compare("macClear", mac_clear_accum, expClr);
         if (expEn) begin
            compare("macData", mac_data, expData);
            compare("macWeight", mac_weight, expWt);
         end
         compare("outValid", out_valid, expOutValid);
         if (expOutValid) begin
            compare("outData", out_data, expOut);
            compare("outSat", out_sat, expSat);
         end
         compare("busy", busy, (beatsInVec != 0));
      end
   end

   // Enable monitor: logs edge index and clear bit of every issued MAC beat
   int enCount = 0;
   int enCyc[0:4095];
   bit enClr[0:4095];

   always @(negedge clk) begin
      if (!rst && mac_enable && enCount < 4096) begin
         enCyc[enCount] = cyc;
         enClr[enCount] = mac_clear_accum;
         enCount++;
      end
   end

   int riseCyc = 0;

   // Present one beat until it is accepted, then optionally idle for gap cycles
   task automatic applyStimulus(input logic [DW-1:0] d, input logic [WW-1:0] w, input int gap);
      bit acc;
      int n;
      in_data   = d;
      in_weight = w;
      in_valid  = 1'b1;
      acc = 0;
      n = 0;
      while (!acc && n < 200) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
         n++;
      end
      if (!acc) compare("beatAcceptTimeout", 0, 1);
      if (gap > 0) begin
         in_valid = 1'b0;
         repeat (gap) begin
            @(posedge clk);
            #1;
         end
      end
   endtask

   task automatic waitValid(input string name);
      int n;
      n = 0;
      while (!out_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!out_valid) compare({name, "Timeout"}, 0, 1);
      riseCyc = cyc;
   endtask

   task automatic checkOutput(input logic [OW-1:0] expD, input bit expS, input string name);
      waitValid(name);
      compare({name, "Data"}, out_data, expD);
      compare({name, "Sat"}, out_sat, expS);
   endtask

   task automatic sendVector(input logic [DW-1:0] d, input logic [WW-1:0] w, input int gap);
      for (int i = 0; i < VL; i++) applyStimulus(d, w, (i == VL - 1) ? 0 : gap);
      in_valid = 1'b0;
   endtask

   task automatic syncEdge();
      @(posedge clk);
      #1;
   endtask

   int base, enBase;

   initial begin
      #2 rst = 1'b1;
      @(negedge clk);
      syncEdge();
      rst = 1'b0;

      // Back-to-back vector of 1.0 * 1.0 -> 8.0, timing and clear framing pinned
      syncEdge();
      base = cyc;
      enBase = enCount;
      sendVector(16'h0400, 8'h40, 0);
      checkOutput(16'h2000, 1'b0, "unitVec");
      compare("unitVecRiseCycle", riseCyc - base, VL + 2);
      repeat (2) syncEdge();
      compare("unitVecEnables", enCount - enBase, VL);
      compare("unitVecFirstClear", enClr[enBase], 1);
      compare("unitVecLastClear", enClr[enBase + VL - 1], 0);

      // Positive and negative saturation
      syncEdge();
      for (int i = 0; i < VL; i++) applyStimulus(16'h7FFF, (i < 4) ? 8'h40 : 8'h00, 0);
      in_valid = 1'b0;
      checkOutput(16'h7FFF, 1'b1, "satPos");
      syncEdge();
      for (int i = 0; i < VL; i++) applyStimulus(16'h8000, (i < 4) ? 8'h40 : 8'h00, 0);
      in_valid = 1'b0;
      checkOutput(16'h8000, 1'b1, "satNeg");

      // Half-LSB value: rounds up or truncates depending on build
      syncEdge();
      for (int i = 0; i < VL; i++) applyStimulus((i == 0) ? 16'h0001 : 16'h0000, 8'h20, 0);
      in_valid = 1'b0;
`ifdef MAC_SEQ_ROUND_EN
      checkOutput(16'h0001, 1'b0, "halfLsb");
`else
      checkOutput(16'h0000, 1'b0, "halfLsb");
`endif

      // Back-pressure: result held while out_ready is low, stray input ignored
      syncEdge();
      out_ready = 1'b0;
      sendVector(16'h0100, 8'h40, 0);
      checkOutput(16'h0800, 1'b0, "holdVec");
      syncEdge();
      for (int i = 0; i < 5; i++) begin
         in_valid  = 1'b1;
         in_data   = 16'h1234;
         in_weight = 8'h7F;
         @(negedge clk);
         compare("holdStableData", out_data, 16'h0800);
         compare("holdInReady", in_ready, 0);
         syncEdge();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      syncEdge();
      sendVector(16'h0400, 8'h40, 0);
      checkOutput(16'h2000, 1'b0, "afterHold");

      // Toggled in_valid: enables two cycles apart, same result
      syncEdge();
      enBase = enCount;
      sendVector(16'h0400, 8'h40, 1);
      checkOutput(16'h2000, 1'b0, "toggleVec");
      compare("toggleSpacing", enCyc[enBase + VL - 1] - enCyc[enBase], 2 * (VL - 1));

      // Reset mid-vector, then a fresh vector must carry clear_accum and ignore old beats
      syncEdge();
      for (int i = 0; i < 3; i++) applyStimulus(16'h7000, 8'h40, 0);
      in_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      syncEdge();
      rst = 1'b0;
      enBase = enCount;
      sendVector(16'h0200, 8'h40, 0);
      checkOutput(16'h1000, 1'b0, "postReset");
      compare("postResetClear", enClr[enBase], 1);

      // Randomized vectors with random gaps and back-pressure
      for (int v = 0; v < 40; v++) begin
         syncEdge();
         out_ready = 1'b0;
         for (int i = 0; i < VL; i++)
            applyStimulus(16'($urandom), 8'($urandom), (i == VL - 1) ? 0 : int'($urandom_range(0, 2)));
         in_valid = 1'b0;
         waitValid("randVec");
         syncEdge();
         repeat ($urandom_range(0, 3)) syncEdge();
         out_ready = 1'b1;
         syncEdge();
      end

      repeat (3) syncEdge();
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

   // Watchdog so the bench can never hang
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation exceeded its time budget");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
